// File: rtl/rv_regfile_np_pkg.sv
// rtl/rv_regfile_np_pkg.sv - shared register-file constants, FSM encodings and index helper
package rv_regfile_np_pkg;

  localparam int RV_RF_AW   = 5;
  localparam int RV_NREGS_E = 16;
  localparam int RV_NREGS_I = 32;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // True for an index that names a real, writable register (not x0, not past the array).
  function automatic logic idx_live(input logic [RV_RF_AW-1:0] idx, input logic [RV_RF_AW:0] nregs);
    return (idx != '0) && ({1'b0, idx} < nregs);
  endfunction

endpackage

// File: rtl/rv_regmem_np.sv
// rtl/rv_regmem_np.sv - one 1R1W synchronous-read register bank with clear-write mux
module rv_regmem_np #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            clr,
  input  logic [IW-1:0]   clr_addr,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wen;
  logic [IW-1:0]   widx;
  logic [XLEN-1:0] wval;

  // The clear sequencer owns the write port while it runs.
  always_comb begin
    wen  = clr || we;
    widx = clr ? clr_addr : waddr;
    wval = clr ? '0 : wdata;
  end

  always_ff @(posedge clk_i) begin
    if (wen) mem[widx] <= wval;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/rv_regfile_np.sv
// rtl/rv_regfile_np.sv - NRP-read/1-write integer register file with X/W bypass
// Optional post-reset clear sequencer enabled by URV_RF_INIT_CLEAR_EN.
module rv_regfile_np
  import rv_regfile_np_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    d_stall_i,
  input  logic [NRP*RV_RF_AW-1:0] rf_rs_i,
  input  logic [NRP*RV_RF_AW-1:0] d_rs_i,
  output logic [NRP*XLEN-1:0]     x_rs_value_o,
  input  logic [RV_RF_AW-1:0]     w_rd_i,
  input  logic [XLEN-1:0]         w_rd_value_i,
  input  logic                    w_rd_store_i,
  input  logic                    w_bypass_rd_write_i,
  input  logic [XLEN-1:0]         w_bypass_rd_value_i,
  output logic                    busy_o
);

  localparam int IW = $clog2(NREGS);
  localparam logic [RV_RF_AW:0] NR = NREGS[RV_RF_AW:0];

  logic [1:0]          state;
  logic                clr;
  logic [RV_RF_AW-1:0] cnt;
  logic                write;
  logic [XLEN-1:0]     bypass_w;

`ifdef URV_RF_INIT_CLEAR_EN
  localparam logic [RV_RF_AW:0] LAST = NREGS[RV_RF_AW:0] - 6'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_RESET;
      cnt   <= 5'd1;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_CLEAR;
          cnt   <= 5'd1;
        end
        ST_CLEAR: begin
          cnt <= cnt + 5'd1;
          if ({1'b0, cnt} == LAST) state <= ST_RUN;
        end
        default: ;
      endcase
    end
  end

  assign clr    = (state == ST_CLEAR);
  assign busy_o = (state != ST_RUN);
`else
  assign state  = ST_RUN;
  assign clr    = 1'b0;
  assign cnt    = '0;
  assign busy_o = 1'b0;
`endif

  assign write = w_rd_store_i && idx_live(w_rd_i, NR) && (state == ST_RUN);

  // Single forwarding register shared by every port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   bypass_w <= '0;
    else if (write) bypass_w <= w_rd_value_i;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [RV_RF_AW-1:0] rs;
    logic [RV_RF_AW-1:0] drs;
    logic [XLEN-1:0]     rdata;
    logic                zr;
    logic                bw;
    logic                bx;

    assign rs  = rf_rs_i[p*RV_RF_AW +: RV_RF_AW];
    assign drs = d_rs_i[p*RV_RF_AW +: RV_RF_AW];

    rv_regmem_np #(.XLEN(XLEN), .NREGS(NREGS), .IW(IW)) u_mem (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .we       (write),
      .waddr    (w_rd_i[IW-1:0]),
      .wdata    (w_rd_value_i),
      .clr      (clr),
      .clr_addr (cnt[IW-1:0]),
      .re       (!d_stall_i),
      .raddr    (rs[IW-1:0]),
      .rdata    (rdata)
    );

    // bw covers same-edge write/read so the array's read-during-write value is never seen.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        zr <= 1'b0;
        bw <= 1'b0;
      end else if (!d_stall_i) begin
        zr <= !idx_live(rs, NR);
        bw <= write && (rs == w_rd_i);
      end
    end

    assign bx = w_bypass_rd_write_i && (w_rd_i == drs) && idx_live(w_rd_i, NR);

    assign x_rs_value_o[p*XLEN +: XLEN] = (busy_o || zr) ? '0 :
                                          bx ? w_bypass_rd_value_i :
                                          bw ? bypass_w : rdata;
  end

endmodule

// File: tb/tb_rv_regfile_np.sv
// tb/tb_rv_regfile_np.sv - scoreboard bench for rv_regfile_np with a behavioural register model
module tb_rv_regfile_np;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NP   = 2;
`ifdef URV_RF_INIT_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              d_stall, w_store, b_wr, busy;
  logic [NP*5-1:0]   rf_rs, d_rs;
  logic [NP*XLEN-1:0] x_val;
  logic [4:0]        w_rd;
  logic [31:0]       w_val, b_val;

  logic        s_stall, s_store, s_bwr, s_busy;
  logic [4:0]  s_rs, s_drs, s_rd;
  logic [31:0] s_x, s_wv, s_bv;

  rv_regfile_np #(.XLEN(XLEN), .NREGS(NR), .NRP(NP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs),
    .x_rs_value_o(x_val), .w_rd_i(w_rd), .w_rd_value_i(w_val), .w_rd_store_i(w_store),
    .w_bypass_rd_write_i(b_wr), .w_bypass_rd_value_i(b_val), .busy_o(busy)
  );

  rv_regfile_np #(.XLEN(32), .NREGS(16), .NRP(1)) dut_e (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(s_stall), .rf_rs_i(s_rs), .d_rs_i(s_drs),
    .x_rs_value_o(s_x), .w_rd_i(s_rd), .w_rd_value_i(s_wv), .w_rd_store_i(s_store),
    .w_bypass_rd_write_i(s_bwr), .w_bypass_rd_value_i(s_bv), .busy_o(s_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural model: register contents plus what each port captured at its last unstalled edge.
  logic [31:0] arch [32];
  logic        lat_zr [NP];
  logic        lat_fw [NP];
  logic [31:0] lat_val [NP];
  logic [31:0] last_w;

  typedef struct packed {
    int unsigned        id;
    logic [NP*XLEN-1:0] v;
  } exp_t;
  exp_t sbq[$];

  task automatic drive(input logic stall, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] drs0, input logic [4:0] drs1,
                       input logic store, input logic [4:0] rd, input logic [31:0] wv,
                       input logic bwr, input logic [31:0] bv);
    logic [4:0]  rs [NP];
    logic [4:0]  drs [NP];
    logic        wr;
    logic [31:0] ev;
    exp_t        e;
    @(negedge clk);
    d_stall = stall; rf_rs = {rs1, rs0}; d_rs = {drs1, drs0};
    w_store = store; w_rd = rd; w_val = wv; b_wr = bwr; b_val = bv;
    rs[0] = rs0; rs[1] = rs1; drs[0] = drs0; drs[1] = drs1;
    wr = store && rd != 5'd0 && int'(rd) < NR;
    for (int p = 0; p < NP; p++) begin
      if (!stall) begin
        lat_zr[p]  = (rs[p] == 5'd0) || (int'(rs[p]) >= NR);
        lat_fw[p]  = wr && (rs[p] == rd);
        lat_val[p] = arch[rs[p]];
      end
    end
    if (wr) begin
      arch[rd] = wv;
      last_w   = wv;
    end
    for (int p = 0; p < NP; p++) begin
      if (lat_zr[p])                                            ev = 32'h0;
      else if (bwr && drs[p] == rd && rd != 5'd0 && int'(rd) < NR) ev = bv;
      else if (lat_fw[p])                                       ev = last_w;
      else                                                      ev = lat_val[p];
      e.v[p*XLEN +: XLEN] = ev;
    end
    e.id = n_cyc;
    n_cyc++;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int p = 0; p < NP; p++)
          check($sformatf("port%0d_cyc%0d", p, e.id), x_val[p*XLEN +: XLEN], e.v[p*XLEN +: XLEN]);
      end
    end
  end

  task automatic s_step(input logic [4:0] rs, input logic [4:0] drs, input logic store,
                        input logic [4:0] rd, input logic [31:0] wv, input logic bwr,
                        input logic [31:0] bv);
    @(negedge clk);
    s_stall = 1'b0; s_rs = rs; s_drs = drs; s_store = store; s_rd = rd; s_wv = wv;
    s_bwr = bwr; s_bv = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string tag);
    int c1, c2;
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        c1++;
        check({tag, "_busy_out_zero"}, x_val[31:0], 32'h0);
      end
      if (s_busy) c2++;
      if (!busy) begin
        w_store = 1'b0;
        b_wr    = 1'b0;
      end
    end
    check({tag, "_busy_cycles_32"}, 32'(c1), CLR_EN ? 32'd31 : 32'd0);
    check({tag, "_busy_cycles_16"}, 32'(c2), CLR_EN ? 32'd15 : 32'd0);
  endtask

  logic [4:0]  r_rd, r_rs0, r_rs1, r_d0, r_d1;
  logic        r_st, r_store, r_bwr;
  logic [31:0] r_wv, r_bv;

  initial begin : stim
    rst_n = 1'b0;
    d_stall = 1'b0; rf_rs = '0; d_rs = '0; w_store = 1'b0; w_rd = '0; w_val = '0;
    b_wr = 1'b0; b_val = '0;
    s_stall = 1'b0; s_rs = '0; s_drs = '0; s_store = 1'b0; s_rd = '0; s_wv = '0;
    s_bwr = 1'b0; s_bv = '0;
    last_w = '0;
    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    for (int p = 0; p < NP; p++) begin
      lat_zr[p] = 1'b0; lat_fw[p] = 1'b0; lat_val[p] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_port0", x_val[31:0], 32'h0);
    check("rst_port1", x_val[63:32], 32'h0);
    check("rst_busy", {31'b0, busy}, 32'(CLR_EN));
    check("rst_busy16", {31'b0, s_busy}, 32'(CLR_EN));
    check("rst_port16", s_x, 32'h0);

    // During the clear, drive a live X-bypass and a store that must both be suppressed.
    if (CLR_EN) begin
      rf_rs = {5'd5, 5'd5}; d_rs = {5'd5, 5'd5}; w_store = 1'b1; w_rd = 5'd5;
      w_val = 32'h5555_5555; b_wr = 1'b1; b_val = 32'hBAD0_BAD0;
    end
    rst_n = 1'b1;
    count_busy("init");

    if (CLR_EN)
      for (int i = 1; i < 32; i++) drive(0, 5'(i), 5'(i), 0, 0, 0, 0, 0, 0, 0);

    for (int i = 1; i < 32; i++)
      drive(0, 0, 0, 0, 0, 1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 0, 0);

    // X-bypass over array value 0x11111111
    drive(0, 0, 0, 0, 0, 1, 5'd5, 32'h1111_1111, 0, 0);
    drive(0, 5'd5, 5'd8, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd5, 5'd8, 5'd5, 0, 0, 5'd5, 0, 1, 32'hDEAD_BEEF);
    // W-bypass on port 1, port 0 reads x8
    drive(0, 5'd8, 5'd7, 0, 0, 1, 5'd7, 32'hCAFE_0001, 0, 0);
    drive(0, 5'd8, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    // x0: write ignored, never bypassed
    drive(0, 0, 0, 0, 0, 1, 5'd0, 32'h5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    drive(0, 5'd3, 5'd3, 0, 0, 0, 0, 0, 1, 32'h77);
    // Stall holds the old x3 while x3 is rewritten
    drive(0, 0, 0, 0, 0, 1, 5'd3, 32'hA, 0, 0);
    drive(0, 5'd3, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 5'd9, 5'd9, 0, 0, 1, 5'd3, 32'hB, 0, 0);
    drive(0, 5'd3, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 5'd3, 5'd3, 0, 0, 0, 0, 0, 0, 0);

    // 16-register instance: out-of-range index behaves like x0
    s_step(0, 0, 1, 5'd4, 32'h44, 0, 0);
    s_step(0, 0, 1, 5'd15, 32'h55, 0, 0);
    s_step(5'd20, 0, 1, 5'd20, 32'h9, 0, 0);
    check("e_x20_read", s_x, 32'h0);
    s_step(5'd4, 0, 1, 5'd0, 32'h5, 0, 0);
    check("e_x4_no_alias", s_x, 32'h44);
    s_step(0, 0, 0, 0, 0, 0, 0);
    check("e_x0_read", s_x, 32'h0);
    s_step(5'd15, 5'd20, 0, 5'd20, 0, 1, 32'hEE);
    check("e_x20_no_bx", s_x, 32'h55);
    s_step(5'd15, 5'd15, 0, 5'd15, 0, 1, 32'hEE);
    check("e_x15_bx", s_x, 32'hEE);

    for (int k = 0; k < 400; k++) begin
      r_rd    = 5'($urandom_range(0, 31));
      r_rs0   = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_rs1   = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_d0    = ($urandom_range(0, 1) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_d1    = ($urandom_range(0, 1) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_st    = (k > 0) && ($urandom_range(0, 3) == 0);
      r_store = 1'($urandom_range(0, 1));
      r_bwr   = ($urandom_range(0, 2) == 0);
      r_wv    = $urandom;
      r_bv    = $urandom;
      drive(r_st, r_rs0, r_rs1, r_d0, r_d1, r_store, r_rd, r_wv, r_bwr, r_bv);
    end

    drive(0, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    d_stall = 1'b0; w_store = 1'b0; b_wr = 1'b0;
    if (CLR_EN) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_port0", x_val[31:0], 32'h0);
    check("midrst_port1", x_val[63:32], 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'(CLR_EN));
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
